uncached_wbuf: RTL and testbench
================================

Name: uncached_wbuf

Overview:
- Write buffer and sequencer for uncached data stores on the d-side AXI write channel.
- Accepts single-beat stores from the d-cache uncached path and queues them in order.
- Drains each store as one AXI transaction (AW + W, then B) to the write-port side of the arbitrater.
- Exposes an address-conflict check so the d-cache can stall an uncached load that would bypass a pending store to the same word.

Parameters:
DEPTH, 4, number of queued stores (power of two, >=2)
ADDR_W, 32, address width
DATA_W, 32, data width (strobe width DATA_W/8)
AXI_ID, 4'h1, constant awid/wid value

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
wb_req  in  1  store push request
wb_addr  in  ADDR_W  store physical address
wb_data  in  DATA_W  store data, lane-aligned
wb_strb  in  DATA_W/8  byte strobes
wb_size  in  3  AXI size of store
wb_ready  out  1  buffer can accept a push this cycle
chk_addr  in  ADDR_W  load address to check
chk_hit  out  1  some valid entry (queued or in flight) matches chk_addr[ADDR_W-1:2]
wb_empty  out  1  no valid entries and channel idle
bus_err  out  1  sticky: some B response had bresp != 0
awid  out  4  = AXI_ID
awaddr  out  ADDR_W  head entry address
awlen  out  8  = 0
awsize  out  3  head entry size
awburst  out  2  = 2'b01 (INCR)
awvalid  out  1  AW valid
awready  in  1  AW ready
wid  out  4  = AXI_ID
wdata  out  DATA_W  head entry data
wstrb  out  DATA_W/8  head entry strobes
wlast  out  1  = 1
wvalid  out  1  W valid
wready  in  1  W ready
bvalid  in  1  B valid
bresp  in  2  B response
bready  out  1  B ready

Behaviour:
- Reset (aresetn low, asynchronous): head/tail pointers 0, count 0, state IDLE, awvalid=wvalid=bready=0, bus_err=0; wb_ready=1, wb_empty=1, chk_hit=0.
- Push: accepted when wb_req && wb_ready. wb_ready = (count < DEPTH), from registered count only. A same-cycle pop never enables a push when full. Entry is written at the tail and the tail advances, wrapping mod DEPTH.
- FSM states: IDLE, SEND, RESP.
  - IDLE: if count != 0, next cycle is SEND with awvalid=wvalid=1 for the head entry. Push at cycle t into an empty idle buffer gives awvalid at t+1.
  - SEND: AW and W are issued concurrently and tracked independently (aw_done, w_done). Each valid drops the cycle after its own handshake. Valids never drop before handshake; payload is stable while valid. When both are done, go to RESP with bready=1.
  - RESP: on bvalid && bready: pop head (head+1 mod DEPTH, count-1), bready=0. If bresp != 0, set bus_err. Next state is SEND if count-1 != 0, else IDLE. There is no idle bubble between back-to-back entries beyond the RESP→SEND edge.
- Simultaneous push and pop: count unchanged; both pointers advance.
- chk_hit is combinational over all valid entries, including the head still in SEND/RESP. An entry stops matching the cycle after its B handshake. A push in the same cycle is not visible until the next cycle.
- wb_empty = (count == 0) && state == IDLE.
- Reset mid-transaction: all state is discarded and valids drop immediately; bus-side recovery is the system's responsibility.
- Strictly in-order: one outstanding AXI write at a time.

Optional Feature:
- Macro: WBUF_MERGE_EN.
- Defined: a push whose word address equals the tail-most valid entry, where that entry is not the head in SEND/RESP, merges into it. Strobes are ORed, data replaced per strobed byte, awsize set to 3'b010, count unchanged. A merge is accepted even when full.
- Undefined: every push allocates a new entry.

Decomposition:
- Package wbuf_pkg:
  - wbuf_entry_t struct (addr, data, strb, size)
  - wbuf_state_t enum {IDLE, SEND, RESP}
  - AXI_BURST_INCR, AXI_RESP_OKAY constants
- Sub-module wbuf_fifo: ring storage with head/tail/count plus per-entry word-address compare vector. The FSM and AXI outputs stay in the top.

Test Plan:
- Single store 0x1FAF_F000/0x12345678/strb 4'hF, awready=wready=1, bvalid 2 cycles later → awvalid one cycle after push, awaddr=0x1FAF_F000, wdata=0x12345678, wlast=1, awlen=0; wb_empty returns to 1 the cycle after B.
- Push 5 stores with awready held 0 (DEPTH=4) → wb_ready=0 after the 4th; 5th held off; after the first B, 5th accepted; AXI order matches push order.
- AW handshake 3 cycles before W handshake → awvalid drops after its handshake, wvalid stays asserted until its own; bready only rises after both.
- Queue store to 0x1FD0_0004, chk_addr=0x1FD0_0006 → chk_hit=1 through RESP; chk_hit=0 the cycle after B; chk_addr=0x1FD0_0008 → 0.
- bresp=2'b10 on one B → bus_err=1 and stays set; later OKAY responses don't clear it; aresetn low clears it.
- With WBUF_MERGE_EN: stores to 0x100 (strb 4'h1, 0xAA) then 0x101 (strb 4'h2, 0xBB00) while head busy elsewhere → one AXI write, wstrb=4'h3, wdata[15:0]=0xBBAA.

Source files
------------

// File: rtl/wbuf_pkg.sv
// Shared types and constants for the uncached store write buffer.
package wbuf_pkg;

    localparam int unsigned WB_ADDR_W = 32;
    localparam int unsigned WB_DATA_W = 32;
    localparam int unsigned WB_STRB_W = WB_DATA_W / 8;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
        logic [WB_STRB_W-1:0] strb;
        logic [2:0]           size;
    } wbuf_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RESP = 2'd2
    } wbuf_state_t;

    // Fold a new store into an existing entry of the same word.
    function automatic wbuf_entry_t wbuf_merge(input wbuf_entry_t old_e, input wbuf_entry_t new_e);
        wbuf_entry_t r;
        r = old_e;
        for (int b = 0; b < int'(WB_STRB_W); b++) begin
            if (new_e.strb[b]) begin
                r.data[8*b +: 8] = new_e.data[8*b +: 8];
            end
        end
        r.strb = old_e.strb | new_e.strb;
        r.size = AXI_SIZE_WORD;
        return r;
    endfunction

endpackage

// File: rtl/uncached_wbuf_if.sv
// AXI write address/data/response channel bundle of the uncached write buffer.
interface uncached_wbuf_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic [3:0]        awid;
    logic [ADDR_W-1:0] awaddr;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;
    logic [3:0]        wid;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    logic              bvalid;
    logic [1:0]        bresp;
    logic              bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bvalid, bresp,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bvalid, bresp,
        input  bready
    );
endinterface

// File: rtl/wbuf_fifo.sv
// Ring storage for queued stores with per-entry word-address compare.
module wbuf_fifo
    import wbuf_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   merge,
    input  logic                   pop,
    input  wbuf_entry_t            wr_entry,
    input  logic [WB_ADDR_W-3:0]   chk_word,
    output wbuf_entry_t            head_entry,
    output wbuf_entry_t            tail_entry,
    output logic [$clog2(DEPTH):0] count,
    output logic [DEPTH-1:0]       match
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wbuf_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] tail_last;

    assign tail_last  = tail - PTR_W'(1);
    assign head_entry = mem[head];
    assign tail_entry = mem[tail_last];

    // Pointer, occupancy and storage update; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[tail] <= wr_entry;
                tail      <= tail + PTR_W'(1);
            end
            if (merge) begin
                mem[tail_last] <= wr_entry;
            end
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Word-address match over occupied slots only.
    always_comb begin
        logic [PTR_W-1:0] offset;
        offset = '0;
        match  = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            offset = PTR_W'(i) - head;
            if ((CNT_W'(offset) < count) &&
                (mem[i].addr[WB_ADDR_W-1:2] == chk_word)) begin
                match[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uncached_wbuf.sv
// Uncached store write buffer: queues single-beat stores and drains them
// in order as one AXI write each. Optional store merging: WBUF_MERGE_EN.
module uncached_wbuf
    import wbuf_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = WB_ADDR_W,
    parameter int unsigned DATA_W = WB_DATA_W,
    parameter logic [3:0]  AXI_ID = 4'h1
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                wb_req,
    input  logic [ADDR_W-1:0]   wb_addr,
    input  logic [DATA_W-1:0]   wb_data,
    input  logic [DATA_W/8-1:0] wb_strb,
    input  logic [2:0]          wb_size,
    output logic                wb_ready,
    input  logic [ADDR_W-1:0]   chk_addr,
    output logic                chk_hit,
    output logic                wb_empty,
    output logic                bus_err,
    uncached_wbuf_if.master     axi
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    wbuf_state_t      state_q, state_d;
    logic             awvalid_q, awvalid_d;
    logic             wvalid_q, wvalid_d;
    logic             bready_q, bready_d;
    logic             bus_err_q, bus_err_d;
    logic             aw_done, w_done;
    logic             pop;
    logic             push;
    logic             merge;
    logic             merge_hit;
    logic             has_room;
    logic [CNT_W-1:0] count;
    logic [DEPTH-1:0] match;
    wbuf_entry_t      new_entry;
    wbuf_entry_t      wr_entry;
    wbuf_entry_t      head_entry;
    wbuf_entry_t      tail_entry;
    logic             unused_bits;

    assign new_entry = '{addr: wb_addr, data: wb_data, strb: wb_strb, size: wb_size};
    assign has_room  = (count < CNT_W'(DEPTH));

`ifdef WBUF_MERGE_EN
    // Merge into the youngest entry unless that entry is the head already on the bus.
    assign merge_hit = (count != '0) &&
                       (tail_entry.addr[ADDR_W-1:2] == wb_addr[ADDR_W-1:2]) &&
                       !((count == CNT_W'(1)) && (state_q != IDLE));
    assign wr_entry    = merge ? wbuf_merge(tail_entry, new_entry) : new_entry;
    assign unused_bits = ^chk_addr[1:0];
`else
    assign merge_hit   = 1'b0;
    assign wr_entry    = new_entry;
    assign unused_bits = ^{chk_addr[1:0], tail_entry};
`endif

    assign wb_ready = has_room || merge_hit;
    assign merge    = wb_req && merge_hit;
    assign push     = wb_req && has_room && !merge_hit;

    wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (aclk),
        .rst_n      (aresetn),
        .push       (push),
        .merge      (merge),
        .pop        (pop),
        .wr_entry   (wr_entry),
        .chk_word   (chk_addr[ADDR_W-1:2]),
        .head_entry (head_entry),
        .tail_entry (tail_entry),
        .count      (count),
        .match      (match)
    );

    // Sequencer state and registered handshake outputs.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Next state: issue AW and W together, retire each on its own handshake, then wait for B.
    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        bus_err_d = bus_err_q;
        aw_done   = 1'b0;
        w_done    = 1'b0;
        pop       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count != '0) begin
                    state_d   = SEND;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                end
            end
            SEND: begin
                aw_done = !awvalid_q || axi.awready;
                w_done  = !wvalid_q || axi.wready;
                if (awvalid_q && axi.awready) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && axi.wready) begin
                    wvalid_d = 1'b0;
                end
                if (aw_done && w_done) begin
                    state_d  = RESP;
                    bready_d = 1'b1;
                end
            end
            RESP: begin
                if (axi.bvalid && bready_q) begin
                    pop      = 1'b1;
                    bready_d = 1'b0;
                    if (axi.bresp != AXI_RESP_OKAY) begin
                        bus_err_d = 1'b1;
                    end
                    if (count != CNT_W'(1)) begin
                        state_d   = SEND;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign chk_hit  = |match;
    assign wb_empty = (count == '0) && (state_q == IDLE);
    assign bus_err  = bus_err_q;

    assign axi.awid    = AXI_ID;
    assign axi.awaddr  = head_entry.addr;
    assign axi.awlen   = 8'h00;
    assign axi.awsize  = head_entry.size;
    assign axi.awburst = AXI_BURST_INCR;
    assign axi.awvalid = awvalid_q;
    assign axi.wid     = AXI_ID;
    assign axi.wdata   = head_entry.data;
    assign axi.wstrb   = head_entry.strb;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;

endmodule

// File: tb/tb_uncached_wbuf.sv
// Self-checking bench for uncached_wbuf: directed scenarios plus random traffic
// against a transaction-level queue model.
module tb_uncached_wbuf;
    import wbuf_pkg::*;

    localparam int DEPTH = 4;

    logic        aclk    = 1'b0;
    logic        aresetn = 1'b1;
    logic        wb_req  = 1'b0;
    logic [31:0] wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic [3:0]  wb_strb = '0;
    logic [2:0]  wb_size = '0;
    logic [31:0] chk_addr = '0;
    logic        wb_ready, chk_hit, wb_empty, bus_err;

    uncached_wbuf_if #(.ADDR_W(32), .DATA_W(32)) axi_if ();

    uncached_wbuf #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32), .AXI_ID(4'h1)) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .wb_req   (wb_req),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .wb_strb  (wb_strb),
        .wb_size  (wb_size),
        .wb_ready (wb_ready),
        .chk_addr (chk_addr),
        .chk_hit  (chk_hit),
        .wb_empty (wb_empty),
        .bus_err  (bus_err),
        .axi      (axi_if)
    );

    always #5 aclk = ~aclk;

    // Model: queue of pending stores (front is the one on the bus) and the phase of the current write.
    wbuf_entry_t mq[$];
    bit m_active, m_aw, m_w, m_b, m_err, m_accept;
    int aw_hs;
    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_mhit();
`ifdef WBUF_MERGE_EN
        if (mq.size() == 0) return 1'b0;
        if (mq[$].addr[31:2] != wb_addr[31:2]) return 1'b0;
        return !(mq.size() == 1 && m_active);
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        foreach (mq[i]) if (mq[i].addr[31:2] == a[31:2]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_active = 0; m_aw = 0; m_w = 0; m_b = 0; m_err = 0; m_accept = 0;
    endtask

    // Advance the model by one clock edge using the inputs applied before the edge.
    task automatic model_update();
        int n0;
        bit mh;
        wbuf_entry_t e, t;
        n0 = mq.size();
        mh = model_mhit();
        e  = '{addr: wb_addr, data: wb_data, strb: wb_strb, size: wb_size};
        m_accept = wb_req && (n0 < DEPTH || mh);
        if (m_aw && axi_if.awready) aw_hs++;
        if (m_accept && mh) begin
            t = mq[$];
            for (int b = 0; b < 4; b++) if (e.strb[b]) t.data[8*b +: 8] = e.data[8*b +: 8];
            t.strb = t.strb | e.strb;
            t.size = 3'b010;
            mq[mq.size()-1] = t;
        end else if (m_accept) begin
            mq.push_back(e);
        end
        if (!m_active) begin
            if (n0 > 0) begin m_active = 1; m_aw = 1; m_w = 1; end
        end else if (m_aw || m_w) begin
            m_aw = m_aw && !axi_if.awready;
            m_w  = m_w && !axi_if.wready;
            if (!m_aw && !m_w) m_b = 1;
        end else if (m_b && axi_if.bvalid) begin
            mq.delete(0);
            if (axi_if.bresp != 2'b00) m_err = 1;
            m_b = 0;
            if (n0 > 1) begin m_aw = 1; m_w = 1; end
            else m_active = 0;
        end
    endtask

    task automatic model_compare();
        chk("awvalid", axi_if.awvalid, m_aw);
        chk("wvalid", axi_if.wvalid, m_w);
        chk("bready", axi_if.bready, m_b);
        chk("wb_ready", wb_ready, (mq.size() < DEPTH) || model_mhit());
        chk("wb_empty", wb_empty, (mq.size() == 0) && !m_active);
        chk("chk_hit", chk_hit, model_hit(chk_addr));
        chk("bus_err", bus_err, m_err);
        if (m_aw) begin
            chk("awaddr", axi_if.awaddr, mq[0].addr);
            chk("awsize", axi_if.awsize, mq[0].size);
            chk("awlen", axi_if.awlen, 8'h00);
            chk("awburst", axi_if.awburst, 2'b01);
            chk("awid", axi_if.awid, 4'h1);
        end
        if (m_w) begin
            chk("wdata", axi_if.wdata, mq[0].data);
            chk("wstrb", axi_if.wstrb, mq[0].strb);
            chk("wlast", axi_if.wlast, 1'b1);
            chk("wid", axi_if.wid, 4'h1);
        end
    endtask

    task automatic cycle();
        @(posedge aclk);
        model_update();
        @(negedge aclk);
        model_compare();
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        model_reset();
        @(posedge aclk);
        @(negedge aclk);
        model_compare();
        aresetn = 1'b1;
    endtask

    task automatic idle_inputs();
        wb_req = 0;
        axi_if.awready = 0; axi_if.wready = 0; axi_if.bvalid = 0; axi_if.bresp = 2'b00;
    endtask

    task automatic push_set(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [2:0] z);
        wb_req = 1; wb_addr = a; wb_data = d; wb_strb = s; wb_size = z;
    endtask

    task automatic drain(input int budget);
        bit done;
        done = 0;
        axi_if.awready = 1; axi_if.wready = 1; axi_if.bvalid = 1; axi_if.bresp = 2'b00;
        for (int k = 0; k < budget; k++) begin
            if (mq.size() == 0 && !m_active) begin done = 1; break; end
            cycle();
        end
        if (!done && mq.size() == 0 && !m_active) done = 1;
        chk("drain_timeout", done, 1'b1);
        idle_inputs();
    endtask

    // Single store through to its B response with the given bresp.
    task automatic do_store(input logic [31:0] a, input logic [1:0] r);
        bit got;
        got = 0;
        push_set(a, 32'hCAFE_0000 | a[15:0], 4'hF, 3'b010);
        cycle();
        wb_req = 0; axi_if.awready = 1; axi_if.wready = 1;
        for (int k = 0; k < 20; k++) begin
            if (m_b) begin got = 1; break; end
            cycle();
        end
        chk("store_reach_resp", got, 1'b1);
        axi_if.bvalid = 1; axi_if.bresp = r;
        cycle();
        idle_inputs();
    endtask

    initial begin
        bit got;
        int hs0;
        idle_inputs();
        do_reset();
        chk("rst_wb_ready", wb_ready, 1'b1);
        chk("rst_wb_empty", wb_empty, 1'b1);
        chk("rst_chk_hit", chk_hit, 1'b0);
        chk("rst_awvalid", axi_if.awvalid, 1'b0);
        chk("rst_bus_err", bus_err, 1'b0);

        // Single store timing and payload.
        push_set(32'h1FAF_F000, 32'h1234_5678, 4'hF, 3'b010);
        axi_if.awready = 1; axi_if.wready = 1;
        cycle();
        chk("t1_no_aw_at_push", axi_if.awvalid, 1'b0);
        wb_req = 0;
        cycle();
        chk("t1_awvalid", axi_if.awvalid, 1'b1);
        chk("t1_awaddr", axi_if.awaddr, 32'h1FAF_F000);
        chk("t1_wdata", axi_if.wdata, 32'h1234_5678);
        chk("t1_wlast", axi_if.wlast, 1'b1);
        chk("t1_awlen", axi_if.awlen, 8'h00);
        cycle();
        chk("t1_bready", axi_if.bready, 1'b1);
        chk("t1_aw_dropped", axi_if.awvalid, 1'b0);
        cycle();
        axi_if.bvalid = 1;
        cycle();
        chk("t1_empty_after_b", wb_empty, 1'b1);
        chk("t1_bready_dropped", axi_if.bready, 1'b0);
        idle_inputs();

        // Fill past capacity with the bus stalled.
        for (int i = 0; i < 4; i++) begin
            push_set(32'h0000_1000 * (i + 1), $urandom, 4'hF, 3'b010);
            cycle();
        end
        push_set(32'h0000_5000, 32'h5555_5555, 4'hF, 3'b010);
        cycle();
        cycle();
        chk("t2_full_not_ready", wb_ready, 1'b0);
        axi_if.awready = 1; axi_if.wready = 1; axi_if.bvalid = 1;
        got = 0;
        for (int k = 0; k < 30; k++) begin
            cycle();
            if (m_accept) begin got = 1; break; end
        end
        chk("t2_fifth_accepted", got, 1'b1);
        wb_req = 0;
        drain(100);

        // AW handshake three cycles ahead of W.
        axi_if.awready = 1;
        push_set(32'h3000_0040, 32'hA5A5_0F0F, 4'hF, 3'b010);
        cycle();
        wb_req = 0;
        cycle();
        cycle();
        chk("t3_aw_dropped", axi_if.awvalid, 1'b0);
        chk("t3_w_held", axi_if.wvalid, 1'b1);
        chk("t3_no_bready", axi_if.bready, 1'b0);
        cycle();
        cycle();
        chk("t3_no_bready_late", axi_if.bready, 1'b0);
        axi_if.wready = 1;
        cycle();
        chk("t3_bready", axi_if.bready, 1'b1);
        axi_if.bvalid = 1;
        cycle();
        idle_inputs();

        // Load-address conflict check across queue, SEND and RESP.
        chk_addr = 32'h1FD0_0006;
        axi_if.awready = 1; axi_if.wready = 1;
        push_set(32'h1FD0_0004, 32'h0BAD_F00D, 4'hF, 3'b010);
        cycle();
        wb_req = 0;
        chk("t4_hit_queued", chk_hit, 1'b1);
        cycle();
        cycle();
        chk("t4_hit_resp", chk_hit, 1'b1);
        chk_addr = 32'h1FD0_0008;
        #1;
        chk("t4_other_word", chk_hit, 1'b0);
        chk_addr = 32'h1FD0_0006;
        #1;
        axi_if.bvalid = 1;
        cycle();
        chk("t4_hit_cleared", chk_hit, 1'b0);
        idle_inputs();

        // Sticky bus error.
        do_store(32'h4000_0000, 2'b10);
        chk("t5_err_set", bus_err, 1'b1);
        do_store(32'h4000_0010, 2'b00);
        chk("t5_err_sticky", bus_err, 1'b1);
        do_reset();
        chk("t5_err_cleared", bus_err, 1'b0);

`ifdef WBUF_MERGE_EN
        // Two byte stores to one word merge behind a busy head.
        push_set(32'h0000_0200, 32'h1111_1111, 4'hF, 3'b010);
        cycle();
        push_set(32'h0000_0100, 32'h0000_00AA, 4'h1, 3'b000);
        cycle();
        push_set(32'h0000_0101, 32'h0000_BB00, 4'h2, 3'b000);
        cycle();
        wb_req = 0;
        hs0 = aw_hs;
        got = 0;
        axi_if.awready = 1; axi_if.wready = 1; axi_if.bvalid = 1;
        for (int k = 0; k < 40; k++) begin
            cycle();
            if (axi_if.awvalid && axi_if.awaddr == 32'h0000_0100 && !got) begin
                got = 1;
                chk("t6_wstrb", axi_if.wstrb, 4'h3);
                chk("t6_wdata", axi_if.wdata[15:0], 16'hBBAA);
                chk("t6_awsize", axi_if.awsize, 3'b010);
            end
            if (mq.size() == 0 && !m_active) break;
        end
        chk("t6_merged_seen", got, 1'b1);
        chk("t6_two_writes", aw_hs - hs0, 2);
        idle_inputs();
`endif

        // Random traffic against the model.
        hs0 = 0;
        for (int it = 0; it < 3000; it++) begin
            wb_req   = 1'($urandom_range(0, 1));
            wb_addr  = 32'h2000_0000 + 32'($urandom_range(0, 5) << 2) + 32'($urandom_range(0, 3));
            wb_data  = $urandom;
            wb_strb  = 4'($urandom_range(1, 15));
            wb_size  = 3'($urandom_range(0, 2));
            chk_addr = 32'h2000_0000 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
            axi_if.awready = ($urandom_range(0, 3) != 0);
            axi_if.wready  = ($urandom_range(0, 3) != 0);
            axi_if.bvalid  = ($urandom_range(0, 2) == 0);
            axi_if.bresp   = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
            cycle();
            if (it % 1000 == 999) begin
                idle_inputs();
                do_reset();
            end
        end
        idle_inputs();
        drain(200);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
